// File: rtl/mips32_pkg.sv
// Shared constants for the Mips32 core and its front end.
// Word width and default fetch-unit geometry.
package mips32_pkg;

  localparam int WORD_W      = 32;
  localparam int IMEM_AW     = 16;
  localparam int FETCH_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/imem_fetch_fifo.sv
// fetch_fifo: in-order prefetch queue of DEPTH words.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int W     = WORD_W,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic [W-1:0]  o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != FULL) || w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rp];

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch unit: prefetches words from a variable-latency
// memory port and presents the word matching the core's raddr.
module imem_fetch
  import mips32_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       raddr,
  input  logic              take,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);

  logic [AW-1:0]     r_fpc;
  logic [AW-1:0]     r_exp;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_drop;

  logic [AW-1:0]     w_addr;
  logic              w_redirect;
  logic              w_valid;
  logic              w_fire;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [CW-1:0]     w_occ;
  logic [CW-1:0]     w_live;
  logic [CW:0]       w_credit;
  logic [CW-1:0]     w_inflight_nxt;
  logic [WORD_W-1:0] w_head;

  if (AW < 32) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^raddr[31:AW];
  end

  assign w_addr     = raddr[AW-1:0];
  assign w_redirect = (w_addr != r_exp);
  assign w_valid    = !w_empty && !w_redirect;

  // Words still to be delivered plus words held must fit the queue.
  assign w_live   = r_inflight - r_drop;
  assign w_credit = {1'b0, w_live} + {1'b0, w_occ};

  assign mem_req  = reset_n && !w_redirect && (w_credit < LIM);
  assign mem_addr = r_fpc;
  assign w_fire   = mem_req && mem_gnt;

  assign w_resp = mem_rvalid && (r_inflight != '0);
  assign w_push = w_resp && (r_drop == '0) && !w_redirect;
  assign w_pop  = take && w_valid;

  assign w_inflight_nxt = r_inflight + CW'(w_fire) - CW'(w_resp);

  assign instr_valid = w_valid;
  assign instr       = w_valid ? w_head : '0;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W),
    .CW    (CW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (mem_rdata),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_count (w_occ),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fpc      <= '0;
      r_exp      <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_redirect) begin
        r_fpc  <= w_addr;
        r_exp  <= w_addr;
        // Nothing fires on redirect, so all remaining flight is stale.
        r_drop <= w_inflight_nxt;
      end else begin
        if (w_fire)
          r_fpc <= r_fpc + 1'b1;
        if (w_pop)
          r_exp <= r_exp + 1'b1;
        if (w_resp && (r_drop != '0))
          r_drop <= r_drop - 1'b1;
      end
    end
  end

  a_rvalid_orphan: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(mem_rvalid && (r_inflight == '0))
  );

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch with a fixed-latency memory model.
// Per-cycle vector tables plus a reset-mid-fetch sequence.
module tb_imem_fetch;
  import mips32_pkg::*;

  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   raddr = '0;
  logic          take = 1'b0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;
  rsp_t pend[$];

  typedef struct {
    logic [AW-1:0] raddr;
    logic          take;
    logic          gnt;
    logic          chk_req;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [AW-1:0] daddr;
  } vec_t;
  vec_t v[$];

  always #5 clock = ~clock;

  imem_fetch #(.DEPTH(4), .AW(AW)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .raddr       (raddr),
    .take        (take),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  always @(posedge clock) cyc++;

  // Memory: a fire seen in cycle c is answered during cycle c+lat.
  always @(negedge clock) begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (!reset_n) begin
      pend.delete();
    end else begin
      if (mem_req && mem_gnt)
        pend.push_back('{mem_addr, cyc + lat});
      if (pend.size() != 0 && pend[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ra, input logic tk,
                              input logic g, input logic cr,
                              input logic rq, input int ad,
                              input logic vl, input int da);
    vec_t r;
    r.raddr   = AW'(ra);
    r.take    = tk;
    r.gnt     = g;
    r.chk_req = cr;
    r.req     = rq;
    r.addr    = AW'(ad);
    r.valid   = vl;
    r.daddr   = AW'(da);
    return r;
  endfunction

  task automatic do_reset(input int l);
    reset_n = 1'b0;
    raddr   = '0;
    take    = 1'b0;
    mem_gnt = 1'b0;
    lat     = l;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.valid", {31'h0, instr_valid}, 32'h0);
    chk("rst.instr", instr, 32'h0);
    chk("rst.req", {31'h0, mem_req}, 32'h0);
    chk("rst.addr", {16'h0, mem_addr}, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run(input string tag);
    logic [31:0] want;
    for (int i = 0; i < v.size(); i++) begin
      raddr   = {16'h0, v[i].raddr};
      take    = v[i].take;
      mem_gnt = v[i].gnt;
      @(negedge clock);
      want = v[i].valid ? word(v[i].daddr) : 32'h0;
      chk($sformatf("%s[%0d].valid", tag, i),
          {31'h0, instr_valid}, {31'h0, v[i].valid});
      chk($sformatf("%s[%0d].instr", tag, i), instr, want);
      if (v[i].chk_req) begin
        chk($sformatf("%s[%0d].req", tag, i),
            {31'h0, mem_req}, {31'h0, v[i].req});
        if (v[i].req)
          chk($sformatf("%s[%0d].addr", tag, i),
              {16'h0, mem_addr}, {16'h0, v[i].addr});
      end
      @(posedge clock);
      #1;
    end
    v.delete();
  endtask

  initial begin
    // Cold start, latency 1: one request and one word per cycle.
    do_reset(1);
    for (int k = 0; k < 10; k++)
      v.push_back(mk(k < 2 ? 0 : k - 2, 1, 1, 1, 1, k, k >= 2, k - 2));
    run("cold");

    // Backpressure: four words buffered, then drained with no grant.
    do_reset(1);
    v.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(5, 0, 1, 1, 1, 5, 0, 0));
    v.push_back(mk(5, 0, 1, 1, 1, 6, 0, 0));
    v.push_back(mk(5, 0, 1, 1, 1, 7, 1, 5));
    v.push_back(mk(5, 0, 1, 1, 1, 8, 1, 5));
    for (int k = 0; k < 5; k++)
      v.push_back(mk(5, 0, 1, 1, 0, 0, 1, 5));
    v.push_back(mk(5, 1, 0, 1, 0, 0, 1, 5));
    v.push_back(mk(6, 1, 0, 0, 0, 0, 1, 6));
    v.push_back(mk(7, 1, 0, 0, 0, 0, 1, 7));
    v.push_back(mk(8, 1, 0, 0, 0, 0, 1, 8));
    v.push_back(mk(9, 1, 0, 1, 1, 9, 0, 0));
    run("bp");

    // Redirect 10 -> 40 with three responses outstanding, latency 3.
    do_reset(3);
    v.push_back(mk(10, 0, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(10, 0, 1, 1, 1, 10, 0, 0));
    v.push_back(mk(10, 0, 1, 1, 1, 11, 0, 0));
    v.push_back(mk(10, 0, 1, 1, 1, 12, 0, 0));
    v.push_back(mk(10, 0, 1, 1, 1, 13, 0, 0));
    v.push_back(mk(40, 1, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(40, 0, 1, 1, 1, 40, 0, 0));
    v.push_back(mk(40, 0, 1, 1, 1, 41, 0, 0));
    v.push_back(mk(40, 0, 1, 1, 1, 42, 0, 0));
    v.push_back(mk(40, 0, 1, 1, 1, 43, 0, 0));
    v.push_back(mk(40, 1, 1, 1, 0, 0, 1, 40));
    v.push_back(mk(41, 1, 1, 1, 1, 44, 1, 41));
    v.push_back(mk(42, 1, 1, 0, 0, 0, 1, 42));
    v.push_back(mk(43, 1, 1, 0, 0, 0, 1, 43));
    run("redir");

    // Address wrap from 0xFFFF to 0 without a redirect.
    do_reset(1);
    v.push_back(mk(16'hFFFE, 1, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(16'hFFFE, 1, 1, 1, 1, 16'hFFFE, 0, 0));
    v.push_back(mk(16'hFFFE, 1, 1, 1, 1, 16'hFFFF, 0, 0));
    v.push_back(mk(16'hFFFE, 1, 1, 1, 1, 0, 1, 16'hFFFE));
    v.push_back(mk(16'hFFFF, 1, 1, 1, 1, 1, 1, 16'hFFFF));
    v.push_back(mk(0, 1, 1, 1, 1, 2, 1, 0));
    v.push_back(mk(1, 1, 1, 1, 1, 3, 1, 1));
    run("wrap");

    // Reset asserted mid-cycle with words buffered and in flight.
    do_reset(3);
    v.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0));
    v.push_back(mk(0, 0, 1, 1, 1, 2, 0, 0));
    v.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    run("mid");
    chk("mid.pre_valid", {31'h0, instr_valid}, 32'h1);
    chk("mid.pre_addr", {16'h0, mem_addr}, 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid.rst_instr", instr, 32'h0);
    chk("mid.rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid.rst_addr", {16'h0, mem_addr}, 32'h0);
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
